tcb_arb_rr: RTL and testbench
=============================

Name: tcb_arb_rr

Overview:
- Round-robin arbiter that shares one TCB subordinate port (e.g. the VIP memory or an SRAM controller) between MN TCB manager ports.
- Grant is same-cycle combinational, so a granted manager sees the subordinate's rdy directly and no latency is added.
- Responses (rdt/err) return to the originating manager exactly DLY cycles after its transfer, tracked by an internal index pipeline.
- Optional per-manager lock keeps the grant across consecutive transfers for atomic sequences.

Parameters:
- MN, 2, number of manager ports (2..16).
- ABW, 32, address width.
- DBW, 32, data width.
- SLW, 8, byte-lane width; BEW = DBW/SLW is derived, not overridable.
- DLY, 1, subordinate read/response latency in cycles (0..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- man_vld  in  MN  per-manager request valid.
- man_lck  in  MN  per-manager lock request, sampled on transfer.
- man_wen  in  MN  per-manager write enable.
- man_adr  in  MN*ABW  per-manager address.
- man_ben  in  MN*BEW  per-manager byte enables.
- man_wdt  in  MN*DBW  per-manager write data.
- man_rdy  out  MN  per-manager ready.
- man_rsp  out  MN  response strobe: 1 cycle, DLY cycles after that manager's transfer.
- man_rdt  out  MN*DBW  per-manager read data.
- man_err  out  MN  per-manager error.
- sub_vld  out  1  subordinate valid.
- sub_wen  out  1  subordinate write enable.
- sub_adr  out  ABW  subordinate address.
- sub_ben  out  BEW  subordinate byte enables.
- sub_wdt  out  DBW  subordinate write data.
- sub_rdy  in  1  subordinate ready.
- sub_rdt  in  DBW  subordinate read data.
- sub_err  in  1  subordinate error.

Behaviour:
- Transfer definitions:
  - Manager transfer: man_trn[i] = man_vld[i] & man_rdy[i].
  - Subordinate transfer: sub_trn = sub_vld & sub_rdy.
- State:
  - ptr: log2(MN) bits, the highest-priority index.
  - lck_act: 1 bit.
  - lck_idx: log2(MN) bits.
  - rsp_pipe: DLY stages of {valid, index}.
- Grant, combinational:
  - If lck_act, then gnt = lck_idx, whether or not that manager is valid.
  - Otherwise gnt is the first i with man_vld[i] set, scanning ptr, ptr+1, ..., wrapping modulo MN.
  - No valid request gives no grant.
- Subordinate and manager outputs:
  - sub_vld = man_vld[gnt] when a grant exists, else 0.
  - sub_wen/adr/ben/wdt are muxed from gnt. When there is no grant they are driven to 0, never X.
  - man_rdy[i] = sub_rdy & (i==gnt) & grant exists. Non-granted managers see rdy=0.
- Pointer update: on sub_trn with lock inactive, ptr <= gnt+1 modulo MN. Wrap from MN-1 goes to 0. No update on idle cycles or while locked.
- Lock state machine, two states:
  - UNLOCKED -> LOCKED on sub_trn with man_lck[gnt]=1; lck_idx <= gnt.
  - LOCKED -> UNLOCKED on sub_trn with man_lck[lck_idx]=0. That transfer is the last locked one, and ptr <= lck_idx+1.
  - While LOCKED with the owner's vld=0, the subordinate sees vld=0 and other managers stay stalled.
- Response routing:
  - Stage 0 = {sub_trn, gnt}. Each stage shifts every clock, unconditionally.
  - man_rsp[i] = valid(stage DLY) & (index==i).
  - man_rdt[i] = sub_rdt when man_rsp[i], else 0.
  - man_err[i] = sub_err when man_rsp[i], else 0.
  - DLY=0: response paths are purely combinational from the current grant.
  - Write transfers also produce man_rsp, so err is reported for writes.
- Simultaneous events: a new transfer in the same cycle a response returns is legal. Pipelined back-to-back transfers from different managers return in issue order.
- Reset (synchronous, rst=1 at posedge clk):
  - ptr=0, lck_act=0, all rsp_pipe valids=0.
  - While rst is asserted, outputs are forced inactive: man_rdy=0, sub_vld=0, man_rsp=0.
  - Reset mid-operation drops in-flight responses; no man_rsp is produced for them after reset.
- Arithmetic: all index math is modulo MN. For non-power-of-2 MN the wrap compares against MN-1, never relying on natural overflow.

Test Plan:
- MN=2, DLY=1, both vld=1 continuously with sub_rdy=1 -> grants alternate 0,1,0,1. Each man_rsp fires 1 cycle after its transfer, with rdt matching the subordinate model.
- MN=4, only man 2 valid, ptr=0 -> gnt=2 immediately, man_rdy=4'b0100, ptr becomes 3. Then man 0 and 3 request -> man 3 is granted first.
- man 1 writes with lck=1 for 3 transfers (adr 0x10, 0x14, 0x18), last with lck=0, while man 0 is valid throughout -> man 0 stalled for 3 transfers, granted on the 4th cycle.
- sub_rdy=0 for 5 cycles with man 0 valid -> no transfer, ptr unchanged, man_rdy[0]=0, no man_rsp.
- DLY=2: issue man0 read 0x00 then man1 read 0x04 back-to-back -> man_rsp[0] at cycle +2, man_rsp[1] at cycle +3; sub_err=1 on the second -> only man_err[1] is asserted.
- Assert rst for 1 cycle with one response in flight -> man_rsp stays 0, ptr=0, lock cleared; the next request from man 1 is granted normally.

Source files
------------

// File: rtl/tcb_arb_rr.sv
// tcb_arb_rr: round-robin arbiter sharing one TCB subordinate among MN managers,
// with optional per-manager lock and a DLY-deep response routing pipeline.
module tcb_arb_rr #(
    parameter  int MN  = 2,
    parameter  int ABW = 32,
    parameter  int DBW = 32,
    parameter  int SLW = 8,
    parameter  int DLY = 1,
    localparam int BEW = DBW/SLW
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [MN-1:0]     man_vld,
    input  logic [MN-1:0]     man_lck,
    input  logic [MN-1:0]     man_wen,
    input  logic [MN*ABW-1:0] man_adr,
    input  logic [MN*BEW-1:0] man_ben,
    input  logic [MN*DBW-1:0] man_wdt,
    output logic [MN-1:0]     man_rdy,
    output logic [MN-1:0]     man_rsp,
    output logic [MN*DBW-1:0] man_rdt,
    output logic [MN-1:0]     man_err,
    output logic              sub_vld,
    output logic              sub_wen,
    output logic [ABW-1:0]    sub_adr,
    output logic [BEW-1:0]    sub_ben,
    output logic [DBW-1:0]    sub_wdt,
    input  logic              sub_rdy,
    input  logic [DBW-1:0]    sub_rdt,
    input  logic              sub_err
);
    localparam int IW = $clog2(MN);

    logic [IW-1:0] ptr, ptr_nxt, lck_idx, idx_nxt, gnt, rsp_idx;
    logic          lck_act, lck_nxt, gnt_v, sub_trn, rsp_v;

    // explicit compare against MN keeps non-power-of-2 wrap correct
    function automatic logic [IW-1:0] inc(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        return IW'(s >= MN ? s - MN : s);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            lck_act <= 1'b0;
            lck_idx <= '0;
        end else begin
            ptr     <= ptr_nxt;
            lck_act <= lck_nxt;
            lck_idx <= idx_nxt;
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        lck_nxt = lck_act;
        idx_nxt = lck_idx;
        if (sub_trn && lck_act && !man_lck[lck_idx]) begin
            lck_nxt = 1'b0;
            ptr_nxt = inc(lck_idx, 1);
        end else if (sub_trn && !lck_act) begin
            ptr_nxt = inc(gnt, 1);
            lck_nxt = man_lck[gnt];
            idx_nxt = man_lck[gnt] ? gnt : lck_idx;
        end
    end

    // descending scan so the lowest offset from ptr wins
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        if (!rst && lck_act) begin
            gnt_v = 1'b1;
            gnt   = lck_idx;
        end else if (!rst) begin
            for (int k = MN-1; k >= 0; k--) begin
                if (man_vld[inc(ptr, k)]) begin
                    gnt_v = 1'b1;
                    gnt   = inc(ptr, k);
                end
            end
        end
    end

    assign sub_vld = gnt_v & man_vld[gnt];
    assign sub_trn = sub_vld & sub_rdy;
    assign sub_wen = gnt_v & man_wen[gnt];
    assign sub_adr = gnt_v ? man_adr[int'(gnt)*ABW +: ABW] : '0;
    assign sub_ben = gnt_v ? man_ben[int'(gnt)*BEW +: BEW] : '0;
    assign sub_wdt = gnt_v ? man_wdt[int'(gnt)*DBW +: DBW] : '0;
    assign man_rdy = (gnt_v && sub_rdy) ? (MN'(1) << gnt) : '0;

    if (DLY == 0) begin : g_comb
        assign rsp_v   = sub_trn;
        assign rsp_idx = gnt;
    end else begin : g_pipe
        logic [DLY-1:0] v;
        logic [IW-1:0]  x [DLY];
        always_ff @(posedge clk) begin
            x[0] <= gnt;
            for (int k = 1; k < DLY; k++) x[k] <= x[k-1];
            if (rst) begin
                v <= '0;
            end else begin
                v[0] <= sub_trn;
                for (int k = 1; k < DLY; k++) v[k] <= v[k-1];
            end
        end
        assign rsp_v   = v[DLY-1];
        assign rsp_idx = x[DLY-1];
    end

    always_comb begin
        man_rsp = '0;
        man_err = '0;
        man_rdt = '0;
        for (int i = 0; i < MN; i++) begin
            man_rsp[i]               = rsp_v & !rst & (rsp_idx == IW'(i));
            man_err[i]               = man_rsp[i] & sub_err;
            man_rdt[i*DBW +: DBW]    = man_rsp[i] ? sub_rdt : '0;
        end
    end
endmodule

// File: tb/tb_tcb_arb_rr.sv
// tb_tcb_arb_rr: directed vector table plus random traffic against a queue-based
// round-robin/lock/response reference model.
module tb_tcb_arb_rr;
    localparam int MN = 4, ABW = 16, DBW = 32, SLW = 8, BEW = 4, DLY = 2;

    logic              clk = 1'b0, rst;
    logic [MN-1:0]     man_vld, man_lck, man_wen, man_rdy, man_rsp, man_err;
    logic [MN*ABW-1:0] man_adr;
    logic [MN*BEW-1:0] man_ben;
    logic [MN*DBW-1:0] man_wdt, man_rdt;
    logic              sub_vld, sub_wen, sub_rdy, sub_err;
    logic [ABW-1:0]    sub_adr;
    logic [BEW-1:0]    sub_ben;
    logic [DBW-1:0]    sub_wdt, sub_rdt;

    always #5 clk = ~clk;

    tcb_arb_rr #(.MN(MN), .ABW(ABW), .DBW(DBW), .SLW(SLW), .DLY(DLY)) dut (
        .clk(clk), .rst(rst),
        .man_vld(man_vld), .man_lck(man_lck), .man_wen(man_wen),
        .man_adr(man_adr), .man_ben(man_ben), .man_wdt(man_wdt),
        .man_rdy(man_rdy), .man_rsp(man_rsp), .man_rdt(man_rdt), .man_err(man_err),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_adr(sub_adr), .sub_ben(sub_ben),
        .sub_wdt(sub_wdt), .sub_rdy(sub_rdy), .sub_rdt(sub_rdt), .sub_err(sub_err)
    );

    typedef struct {
        logic r;
        logic [3:0] v, l, w;
        logic rdy, err;
        logic [15:0] a;
        logic [3:0] xr, xs;
    } vec_t;

    int checks = 0, errors = 0;
    int m_ptr = 0, m_own = -1;
    int hist[$];
    logic [ABW-1:0] adr_m[MN];
    logic [BEW-1:0] ben_m[MN];
    logic [DBW-1:0] wdt_m[MN];
    vec_t tbl[29];

    function automatic vec_t mk(logic r, logic [3:0] v, l, w, logic rdy, err,
                                logic [15:0] a, logic [3:0] xr, xs);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.w = w; t.rdy = rdy; t.err = err;
        t.a = a; t.xr = xr; t.xs = xs;
        return t;
    endfunction

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // model: grant = lock owner or first valid from ptr; response = transfer made DLY cycles ago
    task automatic model_cycle();
        int g, r;
        logic ev;
        logic [3:0] er;
        logic [127:0] ed;
        g = -1;
        if (!rst && m_own >= 0) g = m_own;
        else if (!rst) begin
            for (int k = 0; k < MN; k++) begin
                if (man_vld[(m_ptr+k)%MN]) begin
                    g = (m_ptr+k)%MN;
                    break;
                end
            end
        end
        ev = (g >= 0) && man_vld[g];
        chk("man_rdy", man_rdy, (g >= 0 && sub_rdy) ? (4'(1) << g) : 4'(0));
        chk("sub_vld", sub_vld, ev);
        chk("sub_bus", {sub_wen, sub_adr, sub_ben, sub_wdt},
            g >= 0 ? {man_wen[g], adr_m[g], ben_m[g], wdt_m[g]} : 53'(0));
        r  = rst ? -1 : hist[0];
        er = r >= 0 ? (4'(1) << r) : 4'(0);
        ed = '0;
        for (int i = 0; i < MN; i++) if (r == i) ed[i*DBW +: DBW] = sub_rdt;
        chk("man_rsp", man_rsp, er);
        chk("man_err", man_err, sub_err ? er : 4'(0));
        chk("man_rdt", man_rdt, ed);
        if (rst) begin
            m_ptr = 0;
            m_own = -1;
            for (int k = 0; k < DLY; k++) hist[k] = -1;
        end else begin
            void'(hist.pop_front());
            hist.push_back((ev && sub_rdy) ? g : -1);
            if (ev && sub_rdy) begin
                if (m_own >= 0 && !man_lck[m_own]) begin
                    m_own = -1;
                    m_ptr = (g+1)%MN;
                end else if (m_own < 0) begin
                    m_ptr = (g+1)%MN;
                    if (man_lck[g]) m_own = g;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] v, l, w, input logic rdy, err,
                        input logic use_x, input logic [3:0] xr, xs);
        rst = r; man_vld = v; man_lck = l; man_wen = w;
        sub_rdy = rdy; sub_err = err; sub_rdt = $urandom;
        for (int i = 0; i < MN; i++) begin
            ben_m[i] = BEW'($urandom);
            wdt_m[i] = $urandom;
            man_adr[i*ABW +: ABW] = adr_m[i];
            man_ben[i*BEW +: BEW] = ben_m[i];
            man_wdt[i*DBW +: DBW] = wdt_m[i];
        end
        @(negedge clk);
        if (use_x) begin
            chk("tbl_rdy", man_rdy, xr);
            chk("tbl_rsp", man_rsp, xs);
        end
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < DLY; k++) hist.push_back(-1);
        for (int i = 0; i < MN; i++) adr_m[i] = '0;
        step(1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 4'h0);
        tbl[0]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 16'h0000, 4'b0000, 4'b0000);
        tbl[1]  = mk(0, 4'b0100, 4'b0000, 4'b0000, 1, 0, 16'h0020, 4'b0100, 4'b0000);
        tbl[2]  = mk(0, 4'b1001, 4'b0000, 4'b0000, 1, 0, 16'h0024, 4'b1000, 4'b0000);
        tbl[3]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 16'h0028, 4'b0001, 4'b0100);
        tbl[4]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 16'h0030, 4'b0000, 4'b1000);
        tbl[5]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 16'h0030, 4'b0000, 4'b0001);
        tbl[6]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 16'h0030, 4'b0000, 4'b0000);
        tbl[7]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 16'h0030, 4'b0000, 4'b0000);
        tbl[8]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 16'h0030, 4'b0000, 4'b0000);
        tbl[9]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 16'h0030, 4'b0001, 4'b0000);
        tbl[10] = mk(0, 4'b0011, 4'b0010, 4'b0010, 1, 0, 16'h0010, 4'b0010, 4'b0000);
        tbl[11] = mk(0, 4'b0011, 4'b0010, 4'b0010, 1, 0, 16'h0014, 4'b0010, 4'b0001);
        tbl[12] = mk(0, 4'b0011, 4'b0000, 4'b0010, 1, 0, 16'h0018, 4'b0010, 4'b0010);
        tbl[13] = mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 16'h0040, 4'b0001, 4'b0010);
        tbl[14] = mk(0, 4'b0010, 4'b0010, 4'b0000, 1, 0, 16'h0044, 4'b0010, 4'b0010);
        tbl[15] = mk(0, 4'b0101, 4'b0000, 4'b0000, 1, 0, 16'h0048, 4'b0010, 4'b0001);
        tbl[16] = mk(0, 4'b0010, 4'b0000, 4'b0000, 1, 0, 16'h004c, 4'b0010, 4'b0010);
        tbl[17] = mk(1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 16'h0050, 4'b0000, 4'b0000);
        tbl[18] = mk(0, 4'b0010, 4'b0000, 4'b0000, 1, 0, 16'h0054, 4'b0010, 4'b0000);
        tbl[19] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0058, 4'b0000, 4'b0000);
        tbl[20] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h005c, 4'b0000, 4'b0010);
        tbl[21] = mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 16'h0000, 4'b0001, 4'b0000);
        tbl[22] = mk(0, 4'b0010, 4'b0000, 4'b0000, 1, 0, 16'h0004, 4'b0010, 4'b0000);
        tbl[23] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0008, 4'b0000, 4'b0001);
        tbl[24] = mk(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h000c, 4'b0000, 4'b0010);
        tbl[25] = mk(0, 4'b0011, 4'b0000, 4'b0000, 1, 0, 16'h0060, 4'b0001, 4'b0000);
        tbl[26] = mk(0, 4'b0011, 4'b0000, 4'b0000, 1, 0, 16'h0064, 4'b0010, 4'b0000);
        tbl[27] = mk(0, 4'b0011, 4'b0000, 4'b0000, 1, 0, 16'h0068, 4'b0001, 4'b0001);
        tbl[28] = mk(0, 4'b0011, 4'b0000, 4'b0000, 1, 0, 16'h006c, 4'b0010, 4'b0010);
        for (int n = 0; n < 29; n++) begin
            for (int i = 0; i < MN; i++) adr_m[i] = tbl[n].a;
            step(tbl[n].r, tbl[n].v, tbl[n].l, tbl[n].w, tbl[n].rdy, tbl[n].err,
                 1, tbl[n].xr, tbl[n].xs);
        end
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < MN; i++) adr_m[i] = ABW'($urandom);
            step($urandom_range(0, 63) == 0, 4'($urandom), 4'($urandom & $urandom),
                 4'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), 0, 4'h0, 4'h0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
